// File: rtl/slice_round_engine.sv
// rtl/slice_round_engine.sv - iterative bitsliced 4-lane round engine with rotating key schedule
//
// Applies min(nrounds, ROUNDS) rounds of a 4-lane boolean round function to
// one word, one round per clock. The round key rotates lanes every round and
// folds a round constant into the low lane.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     input handshake; in_ready high only when idle
//   in_data, in_key       plaintext word and initial round key
//   nrounds               requested round count, sampled at acceptance
//   out_valid/out_ready   output handshake; result held while out_valid
//   out_data              result word
//   busy                  high while a block is being processed or held
module slice_round_engine #(
    parameter int LANE   = 8,
    parameter int ROUNDS = 16,
    parameter int RCW    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4*LANE-1:0] in_data,
    input  logic [4*LANE-1:0] in_key,
    input  logic [RCW-1:0]    nrounds,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4*LANE-1:0] out_data,
    output logic              busy
);

    localparam int W = 4 * LANE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [W-1:0]    data_q;
    logic [W-1:0]    key_q;
    logic [RCW-1:0]  cnt_q;
    logic [RCW-1:0]  n_q;
    logic [RCW-1:0]  n_eff;
    logic [RCW-1:0]  cnt_inc;
    logic [LANE-1:0] rc;
    logic [W-1:0]    key_next;
    logic [W-1:0]    round_out;

    function automatic logic [W-1:0] round_f(input logic [W-1:0] x);
        logic [LANE-1:0] a, b, c, d;
        logic [LANE-1:0] s1, s2, s3, s4, s5, s6, s7;
        logic [LANE-1:0] y0, y1, y2, y3;
        a  = x[4*LANE-1:3*LANE];
        b  = x[3*LANE-1:2*LANE];
        c  = x[2*LANE-1:LANE];
        d  = x[LANE-1:0];
        s1 = ~c;
        s2 = d & s1;
        s3 = a ^ b;
        y2 = s3 ^ s2;
        s4 = a | s1;
        s5 = d ^ s4;
        y3 = b ^ s5;
        s6 = c ^ b;
        s7 = s3 & s6;
        y1 = s6 ^ s7;
        y0 = a ^ c ^ (d & b);
        return {y0, y1, y2, y3};
    endfunction

    // Requests above ROUNDS saturate rather than wrap.
    assign n_eff = (nrounds > RCW'(ROUNDS)) ? RCW'(ROUNDS) : nrounds;

    // cnt_q never exceeds ROUNDS-1, so cnt_inc cannot overflow RCW bits.
    // The cast truncates (or zero-extends) to LANE bits, giving the
    // modulo-2^LANE wrap of the round constant.
    assign cnt_inc   = cnt_q + 1'b1;
    assign rc        = LANE'(cnt_inc);
    assign key_next  = {key_q[3*LANE-1:0], key_q[4*LANE-1:3*LANE] ^ rc};
    assign round_out = round_f(data_q) ^ key_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = (n_eff == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt_inc == n_q) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs depend on the registered state only.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE:    in_ready = 1'b1;
            RUN:     busy     = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    // Datapath: the state register doubles as the output register, so a
    // zero-round block simply presents the latched input word.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            key_q  <= '0;
            cnt_q  <= '0;
            n_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_q <= in_data;
                        key_q  <= in_key;
                        n_q    <= n_eff;
                        cnt_q  <= '0;
                    end
                end
                RUN: begin
                    data_q <= round_out;
                    key_q  <= key_next;
                    cnt_q  <= cnt_inc;
                end
                default: begin
                end
            endcase
        end
    end

    assign out_data = data_q;

endmodule

// File: tb/tb_slice_round_engine.sv
// tb/tb_slice_round_engine.sv - self-checking bench for slice_round_engine
module tb_slice_round_engine;

    localparam int LANE   = 8;
    localparam int ROUNDS = 16;
    localparam int RCW    = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [31:0] in_key;
    logic [4:0]  nrounds;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    int total = 0;
    int bad   = 0;

    slice_round_engine #(.LANE(LANE), .ROUNDS(ROUNDS), .RCW(RCW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .nrounds   (nrounds),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: lanes as an array, rounds and key rotation in plain loops.
    function automatic logic [31:0] golden(input logic [31:0] din, input logic [31:0] kin,
                                           input int nr);
        logic [7:0] s [4];
        logic [7:0] k [4];
        logic [7:0] y [4];
        logic [7:0] first;
        int n;
        n = (nr > ROUNDS) ? ROUNDS : nr;
        for (int i = 0; i < 4; i++) begin
            s[i] = din[31-8*i -: 8];
            k[i] = kin[31-8*i -: 8];
        end
        for (int r = 0; r < n; r++) begin
            // lanes: s[0]=a, s[1]=b, s[2]=c, s[3]=d
            y[2] = (s[0] ^ s[1]) ^ (s[3] & ~s[2]);
            y[3] = s[1] ^ s[3] ^ (s[0] | ~s[2]);
            y[1] = (s[2] ^ s[1]) ^ ((s[0] ^ s[1]) & (s[2] ^ s[1]));
            y[0] = s[0] ^ s[2] ^ (s[3] & s[1]);
            for (int i = 0; i < 4; i++) s[i] = y[i] ^ k[i];
            first = k[0];
            for (int i = 0; i < 3; i++) k[i] = k[i+1];
            k[3] = first ^ 8'(r + 1);
        end
        return {s[0], s[1], s[2], s[3]};
    endfunction

    function automatic int exp_lat(input int nr);
        return (nr > ROUNDS) ? ROUNDS : nr;
    endfunction

    // Offers a block, waits for acceptance, then counts edges until out_valid.
    // lat counts edges after the accepting edge; busy_ok records busy staying high.
    task automatic send(input logic [31:0] d, input logic [31:0] k, input logic [4:0] nr,
                        output bit ok, output int lat, output bit busy_ok);
        bit acc;
        ok       = 1'b0;
        in_data  = d;
        in_key   = k;
        nrounds  = nr;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) ok = 1'b1;
        end
        in_valid = 1'b0;
        in_data  = $urandom;
        in_key   = $urandom;
        lat      = 0;
        busy_ok  = 1'b1;
        while (ok && !out_valid && lat < 100) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!busy) busy_ok = 1'b0;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_key = '0; nrounds = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data got=%h want=00000000", out_data); end
    endtask

    task automatic test_directed();
        logic [31:0] td [4];
        logic [31:0] tk [4];
        logic [4:0]  tn [4];
        logic [31:0] te [4];
        bit ok, bok;
        int lat;
        td[0] = 32'h0;        tk[0] = 32'h0;        tn[0] = 5'd1;  te[0] = 32'h000000FF;
        td[1] = 32'h0;        tk[1] = 32'h0;        tn[1] = 5'd2;  te[1] = 32'h0000FF01;
        td[2] = 32'hDEADBEEF; tk[2] = 32'h12345678; tn[2] = 5'd0;  te[2] = 32'hDEADBEEF;
        td[3] = 32'hCAFEF00D; tk[3] = 32'h0BADC0DE; tn[3] = 5'd31;
        te[3] = golden(32'hCAFEF00D, 32'h0BADC0DE, 31);
        for (int i = 0; i < 4; i++) begin
            send(td[i], tk[i], tn[i], ok, lat, bok);
            total++; if (!ok) begin bad++; $display("FAIL dir%0d_accept got=timeout want=accepted", i); end
            total++; if (lat !== exp_lat(int'(tn[i]))) begin bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, exp_lat(int'(tn[i]))); end
            total++; if (out_data !== te[i]) begin bad++; $display("FAIL dir%0d_data got=%h want=%h", i, out_data, te[i]); end
            total++; if (bok !== 1'b1) begin bad++; $display("FAIL dir%0d_busy got=dropped want=held", i); end
            release_out();
            total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL dir%0d_release got=valid%b ready%b want=valid0 ready1", i, out_valid, in_ready); end
        end
    endtask

    task automatic test_backpressure();
        bit ok, bok;
        int lat;
        logic [31:0] e, e2, d2, k2;
        e = golden(32'h01234567, 32'h89ABCDEF, 5);
        send(32'h01234567, 32'h89ABCDEF, 5'd5, ok, lat, bok);
        total++; if (!ok || out_data !== e) begin bad++; $display("FAIL bp_first got=%h want=%h", out_data, e); end
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            in_data  = $urandom;
            in_key   = $urandom;
            nrounds  = 5'($urandom_range(0, 31));
            @(posedge clk);
            #1;
            total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== e) begin
                bad++; $display("FAIL bp_hold%0d got=valid%b ready%b data=%h want=valid1 ready0 data=%h", i, out_valid, in_ready, out_data, e);
            end
        end
        // in_valid coincides with the DONE->IDLE edge and must not be taken.
        in_valid = 1'b1;
        nrounds  = 5'd3;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        total++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL bp_no_early_accept got=ready%b busy%b valid%b want=ready1 busy0 valid0", in_ready, busy, out_valid);
        end
        in_valid = 1'b0;
        d2 = $urandom; k2 = $urandom;
        e2 = golden(d2, k2, 7);
        send(d2, k2, 5'd7, ok, lat, bok);
        total++; if (!ok || lat !== 7 || out_data !== e2) begin
            bad++; $display("FAIL bp_next got=lat%0d data=%h want=lat7 data=%h", lat, out_data, e2);
        end
        release_out();
    endtask

    task automatic test_reset_mid_run();
        bit ok, bok;
        int lat;
        bit acc;
        logic [31:0] d2, k2, e2;
        in_data = 32'h55AA33CC; in_key = 32'hF0F00F0F; nrounds = 5'd16; in_valid = 1'b1;
        acc = in_ready;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        total++; if (acc !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL rst_run_start got=ready%b busy%b want=ready1 busy1", acc, busy); end
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'h0) begin
            bad++; $display("FAIL rst_mid_run got=ready%b busy%b valid%b data=%h want=ready1 busy0 valid0 data=00000000", in_ready, busy, out_valid, out_data);
        end
        d2 = $urandom; k2 = $urandom;
        e2 = golden(d2, k2, 16);
        send(d2, k2, 5'd16, ok, lat, bok);
        total++; if (!ok || lat !== 16 || out_data !== e2) begin
            bad++; $display("FAIL rst_after_block got=lat%0d data=%h want=lat16 data=%h", lat, out_data, e2);
        end
        release_out();
    endtask

    task automatic test_random();
        bit ok, bok;
        int lat, nr, stall;
        logic [31:0] d, k, e;
        for (int b = 0; b < 1000; b++) begin
            d  = $urandom;
            k  = $urandom;
            nr = ($urandom_range(0, 7) == 0) ? $urandom_range(17, 31) : $urandom_range(0, 16);
            e  = golden(d, k, nr);
            send(d, k, 5'(nr), ok, lat, bok);
            total++; if (!ok || lat !== exp_lat(nr) || !bok) begin
                bad++; $display("FAIL rnd%0d_timing got=ok%b lat%0d busy%b want=lat%0d nr=%0d", b, ok, lat, bok, exp_lat(nr), nr);
            end
            total++; if (out_data !== e) begin
                bad++; $display("FAIL rnd%0d_data got=%h want=%h d=%h k=%h nr=%0d", b, out_data, e, d, k, nr);
            end
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
                @(posedge clk);
                #1;
                total++; if (out_valid !== 1'b1 || out_data !== e) begin
                    bad++; $display("FAIL rnd%0d_stall got=valid%b data=%h want=valid1 data=%h", b, out_valid, out_data, e);
                end
            end
            release_out();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
